// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared definitions for the multiply/divide unit.
//   md_state_e  : FSM encodings MD_IDLE / MD_CALC / MD_FIX
//   MD_ITER     : radix-2 steps per operation
//   MD_DIV0_LO  : LO value written on divide by zero
//   md_op_t     : per-operation flags captured at launch
package md_unit_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  localparam int          MD_ITER    = 32;
  localparam logic [31:0] MD_DIV0_LO = 32'hFFFF_FFFF;

  // sa/sb are already qualified with "signed op", so the fix-up stage can
  // use them directly without looking at the unsigned flag again.
  typedef struct packed {
    logic is_mult;
    logic sa;
    logic sb;
    logic div0;
  } md_op_t;

endpackage

// File: rtl/md_negate.sv
// md_negate: conditional two's-complement negate.
//   neg  : 1 = output -din, 0 = pass din through
//   din  : W-bit input
//   dout : W-bit result
// Used for operand magnitudes at launch and for sign fix-up of results.
module md_negate #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/md_unit.sv
// md_unit: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
//   clk, rst     : clock, synchronous active-high reset
//   start        : launch request (ignored while busy)
//   is_mult      : 1 = multiply, 0 = divide
//   is_unsigned  : 1 = unsigned operation
//   op_a, op_b   : multiplicand/dividend, multiplier/divisor
//   rd_is_hi     : read select for rd_data (1 = HI, 0 = LO)
//   rd_data      : combinational HI/LO read
//   busy         : operation in flight
//   done         : one-cycle pulse when HI/LO first show the new result
// Optional feature macro: MD_EARLY_OUT_EN -- multiplies finish as soon as
// the remaining multiplier bits are all zero.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_mult,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             rd_is_hi,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done
);

  md_state_e          state_q;
  md_op_t             op_q;
  logic [WIDTH-1:0]   a_q;      // multiplicand, or dividend bits still to shift in
  logic [WIDTH-1:0]   b_q;      // remaining multiplier bits, or divisor
  logic [2*WIDTH-1:0] acc_q;    // mult: {partial hi, product lo}; div: {rem, quo}
  logic [5:0]         cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q, done_q;

  // ---------------- operand magnitudes at launch ----------------
  logic             sa_in, sb_in;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign sa_in = ~is_unsigned & op_a[WIDTH-1];
  assign sb_in = ~is_unsigned & op_b[WIDTH-1];

  md_negate #(.W(WIDTH)) u_abs_a (.neg(sa_in), .din(op_a), .dout(a_mag));
  md_negate #(.W(WIDTH)) u_abs_b (.neg(sb_in), .din(op_b), .dout(b_mag));

  // ---------------- one radix-2 step ----------------
  // Multiply: add multiplicand into the upper half when the multiplier LSB
  // is set, then shift the 65-bit {carry, acc} right by one.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: shift the next dividend bit into the remainder and trial
  // subtract. The remainder is always < divisor, so the shifted value fits
  // in WIDTH+1 bits and a restore never needs its top bit.
  logic [WIDTH:0]     rem_sh, trial;
  logic [2*WIDTH-1:0] div_next;

  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
  assign trial    = rem_sh - {1'b0, b_q};
  assign div_next = trial[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {trial[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

  // ---------------- early-out ----------------
  // When no multiplier bits remain, the outstanding steps would only shift,
  // so do all of those shifts at once and finish.
  logic               eo_hit;
  logic [2*WIDTH-1:0] eo_acc;

`ifdef MD_EARLY_OUT_EN
  assign eo_hit = op_q.is_mult && (b_q == '0);
  assign eo_acc = acc_q >> (7'(MD_ITER) - {1'b0, cnt_q});
`else
  assign eo_hit = 1'b0;
  assign eo_acc = acc_q;
`endif

  // ---------------- sign fix-up ----------------
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  md_negate #(.W(2*WIDTH)) u_fix_prod (
    .neg(op_q.sa ^ op_q.sb), .din(acc_q), .dout(prod_fix));
  md_negate #(.W(WIDTH)) u_fix_quo (
    .neg(op_q.sa ^ op_q.sb), .din(acc_q[WIDTH-1:0]), .dout(quo_fix));
  // Remainder takes the dividend's sign. On divide by zero the remainder
  // equals |op_a|, so this also reproduces op_a in HI.
  md_negate #(.W(WIDTH)) u_fix_rem (
    .neg(op_q.sa), .din(acc_q[2*WIDTH-1:WIDTH]), .dout(rem_fix));

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        MD_IDLE: begin
          // busy is always low in IDLE, so start alone launches
          if (start) begin
            a_q          <= a_mag;
            b_q          <= b_mag;
            op_q.is_mult <= is_mult;
            op_q.sa      <= sa_in;
            op_q.sb      <= sb_in;
            op_q.div0    <= (op_b == '0);
            acc_q        <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b1;
            state_q      <= MD_CALC;
          end
        end
        MD_CALC: begin
          if (eo_hit) begin
            acc_q   <= eo_acc;
            state_q <= MD_FIX;
          end else begin
            cnt_q <= cnt_q + 6'd1;
            if (op_q.is_mult) begin
              acc_q <= mul_next;
              b_q   <= b_q >> 1;
            end else begin
              acc_q <= div_next;
              a_q   <= a_q << 1;
            end
            if (cnt_q == 6'(MD_ITER - 1))
              state_q <= MD_FIX;
          end
        end
        MD_FIX: begin
          if (op_q.is_mult) begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end else begin
            hi_q <= rem_fix;
            lo_q <= op_q.div0 ? WIDTH'(MD_DIV0_LO) : quo_fix;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= MD_IDLE;
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign rd_data = rd_is_hi ? hi_q : lo_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit.
module tb_md_unit;

`ifdef MD_EARLY_OUT_EN
  localparam int LAT_X0 = 3;
  localparam int LAT_X1 = 4;
`else
  localparam int LAT_X0 = 34;
  localparam int LAT_X1 = 34;
`endif

  logic        clk = 1'b0;
  logic        rst, start, is_mult, is_unsigned, rd_is_hi;
  logic [31:0] op_a, op_b, rd_data;
  logic        busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  md_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_mult(is_mult),
    .is_unsigned(is_unsigned), .op_a(op_a), .op_b(op_b),
    .rd_is_hi(rd_is_hi), .rd_data(rd_data), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    rd_is_hi = 1'b1; #1; hi = rd_data;
    rd_is_hi = 1'b0; #1; lo = rd_data;
  endtask

  // Drive start now; it is sampled at the next rising edge (cycle N).
  task automatic launch(input logic m, input logic u, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; is_mult = m; is_unsigned = u; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // k counts cycles after N; returns the cycle in which done is seen.
  task automatic wait_done(input int limit, output int lat, output logic b_first);
    lat = -1; b_first = 1'bx;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (k == 1) b_first = busy;
      if (done === 1'b1) begin lat = k; break; end
    end
  endtask

  task automatic run_op(input string tag, input logic m, input logic u,
                        input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat; logic b1; logic [31:0] hi, lo;
    launch(m, u, a, b);
    wait_done(60, lat, b1);
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " busy_first"}, 64'(b1), 64'd1);
    chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
    read_hilo(hi, lo);
    chk({tag, " hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, " lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    logic [31:0] hi, lo;
    int          lat;
    logic        b1, saw_done;

    rst = 1'b1; start = 1'b0; is_mult = 1'b0; is_unsigned = 1'b0;
    op_a = '0; op_b = '0; rd_is_hi = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    read_hilo(hi, lo);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Each run_op launches in the done cycle of the previous one.
    run_op("mult 3*-4",  1, 0, 32'd3,          32'hFFFF_FFFC, 34, 32'hFFFF_FFFF, 32'hFFFF_FFF4);
    run_op("multu max",  1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult min^2", 1, 0, 32'h8000_0000, 32'h8000_0000, 34, 32'h4000_0000, 32'h0000_0000);
    run_op("div -7/2",   0, 0, 32'hFFFF_FFF9, 32'd2,          34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu 7/0",   0, 1, 32'd7,          32'd0,          34, 32'h0000_0007, 32'hFFFF_FFFF);
    run_op("div -7/0",   0, 0, 32'hFFFF_FFF9, 32'd0,          34, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div min/-1", 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0000_0000, 32'h8000_0000);
    run_op("div 7/-2",   0, 0, 32'd7,          32'hFFFF_FFFE, 34, 32'h0000_0001, 32'hFFFF_FFFD);

    // start re-asserted mid-operation must be ignored; HI/LO hold old values.
    launch(0, 1, 32'd100, 32'd7);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin lat = k; break; end
      if (k == 10) begin start = 1'b1; op_a = 32'd9; op_b = 32'd9; end
      if (k == 11) start = 1'b0;
      if (k == 20 || k == 33) begin
        read_hilo(hi, lo);
        chk($sformatf("old hi k%0d", k), 64'(hi), 64'h1);
        chk($sformatf("old lo k%0d", k), 64'(lo), 64'hFFFF_FFFD);
      end
    end
    chk("ignored start latency", 64'(lat), 64'd34);
    read_hilo(hi, lo);
    chk("ignored start hi", 64'(hi), 64'd2);
    chk("ignored start lo", 64'(lo), 64'd14);

    // Reset mid-operation aborts with no done pulse.
    launch(1, 1, 32'h1234, 32'h10);
    for (int k = 1; k <= 15; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    read_hilo(hi, lo);
    chk("abort hi", 64'(hi), 64'd0);
    chk("abort lo", 64'(lo), 64'd0);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    chk("abort no done", 64'(saw_done), 64'd0);

    // Small multipliers: early-out latency when enabled, else fixed.
    run_op("mult 5*0", 1, 0, 32'd5, 32'd0, LAT_X0, 32'd0, 32'd0);
    run_op("mult 5*1", 1, 0, 32'd5, 32'd1, LAT_X1, 32'd0, 32'd5);
    run_op("mult -5*1", 1, 0, 32'hFFFF_FFFB, 32'd1, LAT_X1, 32'hFFFF_FFFF, 32'hFFFF_FFFB);

    // Divide latency never shortens.
    launch(0, 1, 32'd100, 32'd1);
    wait_done(60, lat, b1);
    chk("divu 100/1 latency", 64'(lat), 64'd34);
    read_hilo(hi, lo);
    chk("divu 100/1 lo", 64'(lo), 64'd100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
